io_switch_capture: RTL and testbench



---
 rtl/io_pkg.sv | 13 +
 rtl/sync_2ff.sv | 24 ++
 rtl/io_switch_capture.sv | 118 +++++++++++
 tb/tb_io_switch_capture.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared widths and debounce state encoding for the switch capture path
package io_pkg;

    localparam int IO_DATA_W = 32;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } deb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with per-instance reset value
module sync_2ff #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_switch_capture.sv
// rtl/io_switch_capture.sv - debounced key press latches synchronized switches for io0_in
module io_switch_capture
    import io_pkg::*;
#(
    parameter int SW_WIDTH        = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic                 key_n,
    input  logic                 rd_ack,
    output logic [IO_DATA_W-1:0] io0_in,
    output logic                 io0_valid,
    output logic                 overrun,
    output logic                 key_level
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sw_s;
    logic                key_s;

    sync_2ff #(.WIDTH(SW_WIDTH), .RESET_VAL('0)) u_sync_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw),
        .q     (sw_s)
    );

    // Key idles released (high) so reset never looks like a press.
    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_key (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_n),
        .q     (key_s)
    );

    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_q, press_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= UP;
            cnt     <= '0;
            press_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            press_q <= press_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            UP: begin
                if (!key_s) begin
                    state_nxt = WAIT_DOWN;
                    cnt_nxt   = '0;
                end
            end
            WAIT_DOWN: begin
                if (key_s) begin
                    state_nxt = UP;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DOWN;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_nxt = WAIT_UP;
                    cnt_nxt   = '0;
                end
            end
            WAIT_UP: begin
                if (!key_s) begin
                    state_nxt = DOWN;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = UP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = UP;
        endcase
    end

    assign key_level = (state == DOWN) || (state == WAIT_UP);

    // A capture coinciding with rd_ack means the old value was consumed, so overrun clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io0_in    <= '0;
            io0_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (press_q) begin
            io0_in    <= IO_DATA_W'(sw_s);
            io0_valid <= 1'b1;
            if (io0_valid && !rd_ack) begin
                overrun <= 1'b1;
            end else if (io0_valid && rd_ack) begin
                overrun <= 1'b0;
            end
        end else if (rd_ack && io0_valid) begin
            io0_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_switch_capture.sv
// tb/tb_io_switch_capture.sv - table, directed and randomized checks for io_switch_capture
module tb_io_switch_capture;

    localparam int DC = 4;
    localparam int SW = 18;

    logic          clk;
    logic          rst_n;
    logic [SW-1:0] sw;
    logic          key_n;
    logic          rd_ack;
    logic [31:0]   io0_in;
    logic          io0_valid;
    logic          overrun;
    logic          key_level;

    io_switch_capture #(.SW_WIDTH(SW), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .key_n     (key_n),
        .rd_ack    (rd_ack),
        .io0_in    (io0_in),
        .io0_valid (io0_valid),
        .overrun   (overrun),
        .key_level (key_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference: input pipelines, debounced level flips once the synchronized key has
    // disagreed with it for DC+1 consecutive samples; capture lands one edge later.
    logic [1:0]    m_ks;
    logic [SW-1:0] m_ss [2];
    logic          m_level;
    int            m_run;
    logic          m_pend;
    logic          m_valid;
    logic          m_ovr;
    logic [31:0]   m_data;

    task automatic m_reset();
        m_ks = 2'b11; m_ss[0] = '0; m_ss[1] = '0;
        m_level = 1'b0; m_run = 0; m_pend = 1'b0;
        m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
    endtask

    task automatic m_step();
        logic went_down;
        went_down = 1'b0;
        if (m_pend) begin
            m_data = 32'(m_ss[1]);
            if (m_valid) m_ovr = !rd_ack;
            m_valid = 1'b1;
        end else if (rd_ack && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        if ((!m_ks[1]) != m_level) begin
            m_run++;
            if (m_run == DC + 1) begin
                m_level   = !m_level;
                m_run     = 0;
                went_down = m_level;
            end
        end else begin
            m_run = 0;
        end
        m_pend  = went_down;
        m_ks    = {m_ks[0], key_n};
        m_ss[1] = m_ss[0];
        m_ss[0] = sw;
    endtask

    function automatic logic [63:0] pack(logic v, logic o, logic l, logic [31:0] d);
        return {29'd0, v, o, l, d};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (v,o,l,data)", name, act[34:0], exp[34:0]);
    endtask

    task automatic tick();
        if (!rst_n) m_reset(); else m_step();
        @(posedge clk);
        #1;
        chk("model", pack(io0_valid, overrun, key_level, io0_in),
            pack(m_valid, m_ovr, m_level, m_data));
    endtask

    typedef struct {
        logic          key_n;
        logic [SW-1:0] sw;
        logic          rd_ack;
        int            ncyc;
        logic          v;
        logic [31:0]   d;
        logic          o;
        logic          l;
    } vec_t;

    vec_t tbl [11];

    int seg_left;

    initial begin
        tbl[0]  = '{1'b0, 18'h3039, 1'b1, 1,  1'b0, 32'h3039, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 18'h3039, 1'b0, 8,  1'b0, 32'h3039, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 18'h3039, 1'b0, 3,  1'b0, 32'h3039, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 18'h3039, 1'b0, 1,  1'b0, 32'h3039, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 18'h3039, 1'b0, 3,  1'b0, 32'h3039, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 18'h00001, 1'b0, 8, 1'b0, 32'h3039, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 18'h00001, 1'b0, 10, 1'b1, 32'h1,   1'b0, 1'b1};
        tbl[7]  = '{1'b1, 18'h00001, 1'b0, 8, 1'b1, 32'h1,    1'b0, 1'b0};
        tbl[8]  = '{1'b0, 18'h00002, 1'b0, 10, 1'b1, 32'h2,   1'b1, 1'b1};
        tbl[9]  = '{1'b1, 18'h00002, 1'b1, 1, 1'b0, 32'h2,    1'b0, 1'b1};
        tbl[10] = '{1'b1, 18'h00002, 1'b0, 8, 1'b0, 32'h2,    1'b0, 1'b0};

        rst_n = 1'b0; key_n = 1'b1; sw = '0; rd_ack = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) tick();
        chk("reset_state", pack(io0_valid, overrun, key_level, io0_in), 64'd0);
        rst_n = 1'b1;
        tick();

        // Clean press: valid rises exactly 8 edges after key_n falls.
        sw = 18'h3039; key_n = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("press_latency_early", 64'(io0_valid), 64'd0);
        end
        tick();
        chk("press_capture", pack(io0_valid, overrun, key_level, io0_in),
            pack(1'b1, 1'b0, 1'b1, 32'h3039));

        for (int t = 0; t < 11; t++) begin
            key_n = tbl[t].key_n; sw = tbl[t].sw; rd_ack = tbl[t].rd_ack;
            for (int c = 0; c < tbl[t].ncyc; c++) begin
                tick();
                rd_ack = 1'b0;
            end
            chk($sformatf("table_%0d", t), pack(io0_valid, overrun, key_level, io0_in),
                pack(tbl[t].v, tbl[t].o, tbl[t].l, tbl[t].d));
        end

        // Switch activity alone never reaches io0_in.
        for (int i = 0; i < 50; i++) begin
            sw = (i % 2 == 0) ? 18'h3FFFF : 18'h0;
            tick();
            chk("switch_only", pack(io0_valid, overrun, key_level, io0_in),
                pack(1'b0, 1'b0, 1'b0, 32'h2));
        end

        // Press pulse and rd_ack on the same edge: capture wins, overrun clears.
        sw = 18'h5; key_n = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        key_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        sw = 18'h6; key_n = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("simultaneous", pack(io0_valid, overrun, key_level, io0_in),
            pack(1'b1, 1'b0, 1'b1, 32'h6));

        // Reset in WAIT_DOWN with counter at 2, key kept held through and after reset.
        key_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        key_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("reset_mid_debounce", pack(io0_valid, overrun, key_level, io0_in), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("post_reset_latency_early", 64'(io0_valid), 64'd0);
        end
        tick();
        chk("post_reset_capture", pack(io0_valid, overrun, key_level, io0_in),
            pack(1'b1, 1'b0, 1'b1, 32'h6));

        // Randomized bouncy key, switches and reads against the reference.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seg_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (seg_left == 0) begin
                key_n    = 1'($urandom_range(0, 1));
                seg_left = $urandom_range(1, 9);
            end
            seg_left--;
            sw     = SW'($urandom);
            rd_ack = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
